seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed four-digit seven-segment scan controller for the two's-complement display path. Accepts a 16-bit BCD word (four nibbles, digit 3 leftmost) plus a sign flag from the two's-complement-to-BCD converter through a valid/ready handshake, and drives the board's shared segment bus and per-digit anodes. New values are applied only at frame boundaries, so a digit never shows a mix of old and new data.

## Interface
Parameters:
- CLK_DIV, default 100000, clocks per digit dwell; legal range 2..2^20.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  valid: bcd_in/sign_in present a new value.
- ready  out  1  controller can accept a value.
- bcd_in  in  16  four BCD nibbles; [15:12] is digit 3, [3:0] is digit 0.
- sign_in  in  1  1 = negative; digit 3 shows minus.
- an  out  4  digit anodes, active-low, one-hot-low while scanning.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held 1 (off).

## Operation
- Prescaler counts 0..CLK_DIV-1; tick = (prescaler == CLK_DIV-1). On tick, digit index advances 0→1→2→3→0 (wraps).
- Frame boundary = tick while index == 3.
- Handshake FSM, two states: EMPTY (ready=1) and PENDING (ready=0).
  - EMPTY: load=1 captures bcd_in/sign_in into pending register → PENDING.
  - PENDING: load ignored; on frame boundary pending → display register → EMPTY.
- Digit content from display register:
  - Digits 0–2: nibble glyph. Nibbles 0–9 decimal glyphs; A–F hex glyphs.
  - Digit 3: minus glyph (only g lit, seg=7'b0111111) when sign=1; otherwise its nibble glyph.
- an selects the current index (index 0 → an=4'b1110, index 3 → an=4'b0111); seg carries that digit's glyph.

## Timing
- Reset (asynchronous, immediate): prescaler=0, index=0, state EMPTY, pending and display registers 0, sign 0; outputs an=4'b1111, seg=7'h7F, dp=1, ready=1.
- First rising edge after rst_n deasserts: an=4'b1110, seg=glyph of display digit 0 (value 0 → 7'b1000000).
- an/seg are registered; they change on the same edge the index advances. Dwell per digit is exactly CLK_DIV cycles; frame is 4*CLK_DIV cycles.
- Load accepted in cycle N (load & ready) → ready=0 from edge N+1.
- Transfer on frame-boundary edge: new digit 0 shown from that edge; ready=1 on that same edge.
- Load and frame boundary in the same cycle while EMPTY: value captured into pending only; it is displayed at the following frame boundary (worst-case latency 4*CLK_DIV+1 cycles).
- rst_n asserted mid-frame or while PENDING: pending value discarded, all state returns to reset values.

## Configuration
- LEAD_ZERO_BLANK_EN defined: digits 3, 2, 1 that are zero and have only zeros to their left are blanked (seg=7'h7F, anode still scanned); digit 0 never blanked. With sign=1 the minus occupies digit 3 and blanking applies to digits 2 and 1.
- Undefined: all four digits always show their glyphs (leading zeros visible).

## Structure
- Package seg_pkg: NUM_DIGITS=4, glyph constants for 0–F, GLYPH_MINUS, GLYPH_BLANK, the handshake state enum {EMPTY, PENDING}.
- Sub-module seg7_decode: combinational nibble→seven-segment glyph, active-low; instantiated once on the selected digit's nibble.

## Test plan
All with CLK_DIV=4.
- Reset: hold rst_n=0 → an=4'b1111, seg=7'h7F, dp=1, ready=1; release → an cycles 1110,1101,1011,0111 every 4 clocks, seg=7'b1000000 on each (macro off).
- Load bcd_in=16'h0128, sign_in=0 → ready drops next cycle; after next frame boundary digits 0..3 show 8,2,1,0; ready returns 1.
- Load 16'h0010, sign_in=1 → digit 3 seg=7'b0111111, digit 2 0 (or blank with LEAD_ZERO_BLANK_EN), digit 1 shows 1, digit 0 shows 0.
- Load while PENDING (16'h0005 then 16'h0020) → second load ignored, 5 displayed.
- Load coinciding with frame-boundary tick → value not shown until the following boundary (4*CLK_DIV later).
- Assert rst_n mid-frame with value pending → immediate blank outputs, ready=1, after release display shows 0000.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}; a 0 bit lights that segment.
// Contents: digit count, hex glyph set 0-F, minus/blank glyphs, handshake state enum.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // EMPTY: pending register free, ready high. PENDING: waiting for frame end.
  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } hs_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to seven-segment glyph decoder (active-low, {g,f,e,d,c,b,a}).
// Ports: nib_i  - 4-bit value 0..F
//        seg_o  - glyph; 0-9 decimal shapes, A-F hex shapes (b and d lower case).
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    case (nib_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-aligned value updates.
// Ports: clk/rst_n (async active-low); load/ready valid-ready input of bcd_in[15:0] + sign_in;
//        an[3:0] active-low anodes, seg[6:0] {g,f,e,d,c,b,a} active-low, dp held off.
// Optional: define LEAD_ZERO_BLANK_EN to blank leading zero digits 3..1 (digit 0 always shown).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  output logic        ready,
  input  logic [15:0] bcd_in,
  input  logic        sign_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [19:0] PS_MAX = 20'(CLK_DIV - 1);

  logic [19:0] ps_q, ps_d;
  logic [1:0]  idx_q, idx_d;
  hs_state_e   state_q, state_d;
  logic [15:0] pend_bcd_q, pend_bcd_d;
  logic        pend_sign_q, pend_sign_d;
  logic [15:0] disp_bcd_q, disp_bcd_d;
  logic        disp_sign_q, disp_sign_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        tick;
  logic        frame_end;
  logic [3:0]  sel_nib;
  logic [6:0]  sel_glyph;
  logic [3:0]  blank;

  assign tick      = (ps_q == PS_MAX);
  assign frame_end = tick && (idx_q == 2'd3);

  // Prescaler and digit index.
  always_comb begin
    ps_d  = ps_q + 20'd1;
    idx_d = idx_q;
    if (tick) begin
      ps_d  = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Handshake FSM: one-deep pending slot, drained only at a frame boundary so a
  // frame is never a mix of old and new digits. A load arriving on the boundary
  // itself lands in the slot and waits for the next boundary.
  always_comb begin
    state_d     = state_q;
    pend_bcd_d  = pend_bcd_q;
    pend_sign_d = pend_sign_q;
    disp_bcd_d  = disp_bcd_q;
    disp_sign_d = disp_sign_q;
    case (state_q)
      EMPTY: begin
        if (load) begin
          pend_bcd_d  = bcd_in;
          pend_sign_d = sign_in;
          state_d     = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          disp_bcd_d  = pend_bcd_q;
          disp_sign_d = pend_sign_q;
          state_d     = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign ready = (state_q == EMPTY);

  // an/seg are registered, so they are computed from the next index and the
  // next display value: the new frame appears on the very edge it is transferred.
  always_comb begin
    sel_nib = disp_bcd_d[3:0];
    case (idx_d)
      2'd0: sel_nib = disp_bcd_d[3:0];
      2'd1: sel_nib = disp_bcd_d[7:4];
      2'd2: sel_nib = disp_bcd_d[11:8];
      2'd3: sel_nib = disp_bcd_d[15:12];
      default: sel_nib = disp_bcd_d[3:0];
    endcase
  end

  seg7_decode u_dec (
    .nib_i (sel_nib),
    .seg_o (sel_glyph)
  );

`ifdef LEAD_ZERO_BLANK_EN
  // A minus sign counts as "leading" so zeros right of it still blank.
  logic lead3;
  always_comb begin
    lead3    = disp_sign_d || (disp_bcd_d[15:12] == 4'h0);
    blank    = '0;
    blank[3] = !disp_sign_d && (disp_bcd_d[15:12] == 4'h0);
    blank[2] = lead3 && (disp_bcd_d[11:8] == 4'h0);
    blank[1] = blank[2] && (disp_bcd_d[7:4] == 4'h0);
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    an_d  = ~(4'b0001 << idx_d);
    seg_d = sel_glyph;
    if ((idx_d == 2'd3) && disp_sign_d) begin
      seg_d = GLYPH_MINUS;
    end else if (blank[idx_d]) begin
      seg_d = GLYPH_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q        <= '0;
      idx_q       <= '0;
      state_q     <= EMPTY;
      pend_bcd_q  <= '0;
      pend_sign_q <= 1'b0;
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= GLYPH_BLANK;
    end else begin
      ps_q        <= ps_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      pend_bcd_q  <= pend_bcd_d;
      pend_sign_q <= pend_sign_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_sign_q <= disp_sign_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4.
// k counts rising edges since the last reset release; after edge k the shown
// digit is (k/4)%4 and frame boundaries fall on edges k = 16, 32, 48, ...
module tb_seg_scan_ctrl;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GM = 7'b0111111;
  localparam logic [6:0] GB = 7'h7F;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] LZ = GB;
`else
  localparam logic [6:0] LZ = G0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        ready;
  logic [15:0] bcd_in;
  logic        sign_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ready   (ready),
    .bcd_in  (bcd_in),
    .sign_in (sign_in),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int t);
    while (k < t) step();
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    rst_n = 1'b0; load = 1'b0; bcd_in = '0; sign_in = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an); else n_pass++;
    n_checks++; if (seg !== GB) $display("FAIL reset_seg: got %b want %b", seg, GB); else n_pass++;
    n_checks++; if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      ea = 4'b0001 << ((k / 4) % 4);
      ea = ~ea;
      n_checks++; if (an !== ea) $display("FAIL scan_an k=%0d: got %b want %b", k, an, ea); else n_pass++;
      n_checks++; if (seg !== G0) $display("FAIL scan_seg k=%0d: got %b want %b", k, seg, G0); else n_pass++;
    end
    n_checks++; if (dp !== 1'b1) $display("FAIL scan_dp: got %b want 1", dp); else n_pass++;
  endtask

  task automatic test_load_0128();
    logic [6:0] exp_seg [4];
    logic [3:0] ea;
    exp_seg[0] = G8; exp_seg[1] = G2; exp_seg[2] = G1; exp_seg[3] = LZ;
    run_to(18);
    n_checks++; if (ready !== 1'b1) $display("FAIL l128_ready_before: got %b want 1", ready); else n_pass++;
    load = 1'b1; bcd_in = 16'h0128; sign_in = 1'b0;
    step();
    load = 1'b0;
    n_checks++; if (ready !== 1'b0) $display("FAIL l128_ready_drop: got %b want 0", ready); else n_pass++;
    run_to(31);
    n_checks++; if (ready !== 1'b0) $display("FAIL l128_ready_hold: got %b want 0", ready); else n_pass++;
    n_checks++; if (seg !== LZ) $display("FAIL l128_old_d3: got %b want %b", seg, LZ); else n_pass++;
    run_to(32);
    n_checks++; if (ready !== 1'b1) $display("FAIL l128_ready_back: got %b want 1", ready); else n_pass++;
    for (int d = 0; d < 4; d++) begin
      run_to(32 + 4 * d);
      ea = 4'b0001 << d;
      ea = ~ea;
      n_checks++; if (an !== ea) $display("FAIL l128_an d%0d: got %b want %b", d, an, ea); else n_pass++;
      n_checks++; if (seg !== exp_seg[d]) $display("FAIL l128_seg d%0d: got %b want %b", d, seg, exp_seg[d]); else n_pass++;
    end
  endtask

  task automatic test_sign();
    logic [6:0] exp_seg [4];
    exp_seg[0] = G0; exp_seg[1] = G1; exp_seg[2] = LZ; exp_seg[3] = GM;
    run_to(50);
    load = 1'b1; bcd_in = 16'h0010; sign_in = 1'b1;
    step();
    load = 1'b0; sign_in = 1'b0;
    for (int d = 0; d < 4; d++) begin
      run_to(64 + 4 * d);
      n_checks++; if (seg !== exp_seg[d]) $display("FAIL sign_seg d%0d: got %b want %b", d, seg, exp_seg[d]); else n_pass++;
    end
  endtask

  task automatic test_pending_ignore();
    logic [6:0] exp_seg [4];
    exp_seg[0] = G5;
`ifdef LEAD_ZERO_BLANK_EN
    exp_seg[1] = GB; exp_seg[2] = GB; exp_seg[3] = GB;
`else
    exp_seg[1] = G0; exp_seg[2] = G0; exp_seg[3] = G0;
`endif
    run_to(82);
    load = 1'b1; bcd_in = 16'h0005; sign_in = 1'b0;
    step();
    load = 1'b0;
    run_to(84);
    n_checks++; if (ready !== 1'b0) $display("FAIL pend_ready: got %b want 0", ready); else n_pass++;
    load = 1'b1; bcd_in = 16'h0020;
    step();
    load = 1'b0;
    for (int d = 0; d < 4; d++) begin
      run_to(96 + 4 * d);
      n_checks++; if (seg !== exp_seg[d]) $display("FAIL pend_seg d%0d: got %b want %b", d, seg, exp_seg[d]); else n_pass++;
    end
  endtask

  task automatic test_boundary_load();
    run_to(111);
    n_checks++; if (an !== 4'b0111) $display("FAIL bnd_an_pre: got %b want 0111", an); else n_pass++;
    load = 1'b1; bcd_in = 16'h0007; sign_in = 1'b0;
    step();
    load = 1'b0;
    n_checks++; if (ready !== 1'b0) $display("FAIL bnd_ready: got %b want 0", ready); else n_pass++;
    n_checks++; if (an !== 4'b1110) $display("FAIL bnd_an: got %b want 1110", an); else n_pass++;
    n_checks++; if (seg !== G5) $display("FAIL bnd_old_d0: got %b want %b", seg, G5); else n_pass++;
    run_to(127);
    n_checks++; if (ready !== 1'b0) $display("FAIL bnd_ready_hold: got %b want 0", ready); else n_pass++;
    run_to(128);
    n_checks++; if (seg !== G7) $display("FAIL bnd_new_d0: got %b want %b", seg, G7); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL bnd_ready_back: got %b want 1", ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    run_to(130);
    load = 1'b1; bcd_in = 16'h0999; sign_in = 1'b1;
    step();
    load = 1'b0; sign_in = 1'b0;
    run_to(134);
    n_checks++; if (ready !== 1'b0) $display("FAIL rmid_pending: got %b want 0", ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (an !== 4'b1111) $display("FAIL rmid_an: got %b want 1111", an); else n_pass++;
    n_checks++; if (seg !== GB) $display("FAIL rmid_seg: got %b want %b", seg, GB); else n_pass++;
    n_checks++; if (dp !== 1'b1) $display("FAIL rmid_dp: got %b want 1", dp); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", ready); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    step();
    n_checks++; if (an !== 4'b1110) $display("FAIL rmid_rel_an: got %b want 1110", an); else n_pass++;
    n_checks++; if (seg !== G0) $display("FAIL rmid_rel_seg: got %b want %b", seg, G0); else n_pass++;
    run_to(16);
    n_checks++; if (seg !== G0) $display("FAIL rmid_disc_d0: got %b want %b", seg, G0); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL rmid_disc_ready: got %b want 1", ready); else n_pass++;
    run_to(28);
    n_checks++; if (seg !== LZ) $display("FAIL rmid_disc_d3: got %b want %b", seg, LZ); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_0128();
    test_sign();
    test_pending_ignore();
    test_boundary_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
